// File: rtl/dbg_uart_pkg.sv
// dbg_uart_pkg: register offsets, STATUS bit positions and serialiser states for dbg_uart_tx
package dbg_uart_pkg;
    localparam logic [3:0] DATA_OFS   = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] DIV_OFS    = 4'h8;
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
endpackage

// File: rtl/dbg_uart_fifo.sv
// dbg_uart_fifo: synchronous byte FIFO with first-word fall-through head
// Ports: clk, reset_n (async active-low), push_i/wdata_i write side,
//        pop_i/rdata_o read side, full_o, empty_o, count_o occupancy.
module dbg_uart_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;
    // a pop frees a slot in the same cycle, so a push while full is accepted then
    assign rd      = pop_i && !empty_o;
    assign wr      = push_i && (!full_o || rd);
    assign rdata_o = mem_q[rp_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= wdata_i;
    end
endmodule

// File: rtl/dbg_uart.sv
// dbg_uart_tx: memory-mapped 8N1 debug UART transmitter with byte FIFO and retire strobe
// Ports: clk, reset_n (async active-low); bus addr_i/wdata_i/we_i/re_i -> rdata_o (registered);
//        tx_o serial line (idle high); tx_byte_o/tx_done_o per-byte retire; irq_o empty-and-idle.
module dbg_uart_tx
    import dbg_uart_pkg::*;
#(
    parameter logic [31:0]      BASE_ADDR  = 32'hE000_0000,
    parameter int               FIFO_DEPTH = 16,
    parameter int               DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RESET  = 16'd867
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  we_i,
    input  logic        re_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic [7:0]  tx_byte_o,
    output logic        tx_done_o,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] timer_q, timer_d, divl_q, divl_d, div_q, div_d;
    logic [7:0]       shift_q, shift_d, cur_q, cur_d, byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic [31:0]      rdata_q, rdata_d, status;
    logic             ovf_q, ovf_d, tx_q, tx_d, done_q, done_d, irq_q, irq_d;
    logic             hit, push, pop, drop, div_we, st_rd, tick, full, empty;
    logic [7:0]       head;
    logic [AW:0]      count;
    logic             unused_bits;
    assign unused_bits = ^{wdata_i, we_i};
    assign hit    = addr_i[31:4] == BASE_ADDR[31:4];
    assign push   = hit && addr_i[3:0] == DATA_OFS && we_i[0];
    assign div_we = hit && addr_i[3:0] == DIV_OFS && we_i[1:0] == 2'b11;
    assign st_rd  = re_i && hit && addr_i[3:0] == STATUS_OFS;
    // full implies non-empty, so a pop in the same cycle always makes room
    assign drop   = push && full && !pop;
    assign tick   = timer_q == '0;
    dbg_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata_i[7:0]),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            divl_q  <= DIV_RESET;
            div_q   <= DIV_RESET;
            shift_q <= '0;
            cur_q   <= '0;
            bit_q   <= '0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            byte_q  <= '0;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            divl_q  <= divl_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            cur_q   <= cur_d;
            bit_q   <= bit_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            byte_q  <= byte_d;
            irq_q   <= irq_d;
        end
    end
    // divl_q holds the divisor latched at frame start so DIV writes never disturb a frame in flight
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        divl_d  = divl_q;
        shift_d = shift_q;
        cur_d   = cur_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            if (!empty) begin
                pop     = 1'b1;
                shift_d = head;
                cur_d   = head;
                timer_d = div_q;
                divl_d  = div_q;
                state_d = START;
            end
        end else begin
            timer_d = tick ? divl_q : timer_q - 1'b1;
            if (tick) begin
                state_d = state_q == START ? DATA : state_q == STOP ? IDLE : bit_q == 3'd7 ? STOP : DATA;
                bit_d   = state_q == DATA ? bit_q + 1'b1 : 3'd0;
                shift_d = state_q == DATA ? shift_q >> 1 : shift_q;
            end
        end
    end
    // outputs are computed from next state so the line and strobes come straight off flops
    always_comb begin
        tx_d   = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
        done_d = state_d == STOP && timer_d == '0;
        byte_d = done_d ? cur_d : byte_q;
        irq_d  = empty && state_q == IDLE;
    end
    always_comb begin
        status                   = '0;
        status[ST_FULL]          = full;
        status[ST_EMPTY]         = empty;
        status[ST_BUSY]          = state_q != IDLE;
        status[ST_OVF]           = ovf_q;
        status[ST_CNT_LSB +: 8]  = 8'(count);
        div_d   = div_we ? wdata_i[DIV_W-1:0] : div_q;
        ovf_d   = drop | (ovf_q & ~st_rd);
        rdata_d = !re_i ? rdata_q : !hit ? '0 : addr_i[3:0] == STATUS_OFS ? status :
                  addr_i[3:0] == DIV_OFS ? 32'(div_q) : '0;
    end
    assign rdata_o   = rdata_q;
    assign tx_o      = tx_q;
    assign tx_byte_o = byte_q;
    assign tx_done_o = done_q;
    assign irq_o     = irq_q;
endmodule

// File: doc/dbg_uart_tx.md
Name: dbg_uart_tx

Overview:
- Memory-mapped debug UART transmitter on the HF-RISC data bus.
- Software writes bytes to a DATA register. The bytes are buffered in a FIFO and serialised 8N1, LSB first, on tx_o.
- It drives the serial line that the debug UART callbacks decode.
- It also emits a per-byte retire strobe, so the monitor can capture characters without re-sampling the line.

Parameters:
- BASE_ADDR, 32'hE000_0000, base of the 3-word register window.
- FIFO_DEPTH, 16, byte FIFO entries. Must be a power of two, 2..256.
- DIV_W, 16, width of the baud divisor.
- DIV_RESET, 16'd867, divisor after reset. Bit period = divisor+1 clk cycles.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- addr_i  in  32  bus address
- wdata_i  in  32  bus write data
- we_i  in  4  byte write enables, single-cycle strobe
- re_i  in  1  read strobe, single cycle
- rdata_o  out  32  read data, registered
- tx_o  out  1  serial line, idle high
- tx_byte_o  out  8  byte just completed
- tx_done_o  out  1  one-cycle pulse at end of stop bit
- irq_o  out  1  high while FIFO empty and transmitter idle

Behaviour:
- Reset, asynchronous active-low. Values while reset_n is low:
  - tx_o=1, rdata_o=0, tx_byte_o=0, tx_done_o=0, irq_o=1.
  - FIFO empty, overflow=0, divisor=DIV_RESET, FSM in IDLE.
- Reset mid-frame aborts the frame immediately. tx_o returns high and no tx_done_o pulse is produced.
- Register map, decoded on addr_i[31:4]==BASE_ADDR[31:4]:
  - Offset 0x0 DATA, write-only. Push happens when we_i[0]=1 and pushes wdata_i[7:0]. Reads return 0.
  - Offset 0x4 STATUS, read-only:
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow.
    - bits[15:8] FIFO count.
    - Reading STATUS clears overflow in the same cycle as the read. rdata_o still shows overflow=1.
  - Offset 0x8 DIV, read/write. Write needs we_i[1:0]==2'b11 and loads wdata_i[DIV_W-1:0]. Reads are zero-extended.
  - Other offsets: writes are ignored, reads return 0.
- Read latency: rdata_o is valid 1 cycle after re_i. It holds until the next read.
- Push semantics:
  - A push while full, with no pop that cycle, drops the byte and sets overflow.
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop, load the shift register, latch the divisor into the bit timer, and go to START.
  - START: tx_o=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for one bit period per bit. Shift right and increment the index. After index 7 go to STOP.
  - STOP: tx_o=1 for one bit period.
    - At its last cycle, pulse tx_done_o=1 and set tx_byte_o to the byte just sent.
    - Then go to IDLE.
- Latency: a push into an empty FIFO with the FSM idle shows tx_o=0 two cycles after the we_i cycle (cycle 1 FIFO write, cycle 2 pop and START).
- Frame timing:
  - A full frame is exactly 10*(div+1) cycles.
  - Back-to-back bytes: IDLE lasts exactly one cycle between frames, so there is no extra gap beyond that cycle.
- Divisor writes take effect at the next IDLE->START transition. A frame in flight is unaffected. div=0 gives 1 cycle per bit.
- irq_o is registered: empty && IDLE.

Decomposition:
- Shared package dbg_uart_pkg:
  - register offsets (DATA_OFS, STATUS_OFS, DIV_OFS)
  - STATUS bit positions
  - FSM state enum (IDLE, START, DATA, STOP)
- One sub-module, dbg_uart_fifo: synchronous byte FIFO with push/pop/full/empty/count, parameterised by depth.
- The top level holds the decode, registers, and the serialiser FSM.

Test Plan:
- Reset then idle 50 cycles -> tx_o stays 1, irq_o=1, STATUS read gives 0x0000_0002.
- Set DIV=3, write 0x55 -> START begins 2 cycles after the write, 4 cycles per bit. Line shows 0,1,0,1,0,1,0,1,0,1. tx_done_o pulses with tx_byte_o=0x55 at cycle 41 after the write.
- DIV=0, write 0x41,0x42,0x43 on consecutive cycles -> three 10-cycle frames with one IDLE cycle between each. tx_done_o pulses 3 times with 0x41,0x42,0x43 in order.
- FIFO_DEPTH=16, DIV=100:
  - Write 18 bytes back-to-back -> first byte popped; 16 held; 18th dropped. STATUS shows full=1, overflow=1.
  - A second STATUS read shows overflow=0.
- Mid-frame DIV write (3->7) during byte 0x0F -> byte 0x0F keeps 4-cycle bits, the next byte uses 8-cycle bits.
- Assert reset_n low during the DATA state of 0xA5 -> tx_o=1 immediately, no tx_done_o pulse. After release: empty FIFO, DIV=DIV_RESET.
